// File: rtl/fp_round_pkg.sv
// Shared types for the pipelined mantissa rounder.
//   rnd_mode_e  : IEEE-754 rounding mode encoding used on i_rnd_mode
//   s1_flags_t  : control part of the stage-1 payload (mantissa/exponent
//                 are held alongside it because their widths are parameters)
//   to_infinity : which modes saturate to infinity on exponent overflow
package fp_round_pkg;

  typedef enum logic [1:0] {
    RNE = 2'b00,
    RTZ = 2'b01,
    RUP = 2'b10,
    RDN = 2'b11
  } rnd_mode_e;

  typedef struct packed {
    logic      sign;
    rnd_mode_e mode;
    logic      inc;
    logic      inexact;
  } s1_flags_t;

  function automatic logic to_infinity(input rnd_mode_e mode, input logic sign);
    return (mode == RNE) || (mode == RUP && !sign) || (mode == RDN && sign);
  endfunction

endpackage

// File: rtl/round_decide.sv
// Combinational rounding decision.
//   man         : normalised extended mantissa (hidden bit at MSB)
//   exp_special : exponent is all-ones (Inf/NaN): no rounding applied
//   sign, mode  : result sign and rounding mode
//   inc         : add one ulp to the truncated mantissa
//   inexact     : any discarded bit (G/R/S) is set
module round_decide
  import fp_round_pkg::*;
#(
  parameter int unsigned SIZE_MAN        = 28,
  parameter int unsigned SIZE_MAN_RESULT = 24
) (
  input  logic [SIZE_MAN-1:0] man,
  input  logic                exp_special,
  input  logic                sign,
  input  logic [1:0]          mode,
  output logic                inc,
  output logic                inexact
);

  localparam int unsigned G_POS = SIZE_MAN - SIZE_MAN_RESULT - 1;

  logic l_bit, g_bit, r_bit, s_bit, any_lost;

  assign l_bit    = man[SIZE_MAN-SIZE_MAN_RESULT];
  assign g_bit    = man[G_POS];
  assign r_bit    = man[G_POS-1];
  assign s_bit    = |man[G_POS-2:0];
  assign any_lost = g_bit | r_bit | s_bit;

  always_comb begin
    inc     = 1'b0;
    inexact = 1'b0;
    if (!exp_special) begin
      inexact = any_lost;
      unique case (rnd_mode_e'(mode))
        RNE: inc = g_bit & (r_bit | s_bit | l_bit);
        RTZ: inc = 1'b0;
        RUP: inc = ~sign & any_lost;
        RDN: inc = sign & any_lost;
      endcase
    end
  end

endmodule

// File: rtl/rounding_pipe_unit.sv
// Two-stage pipelined IEEE-754 mantissa rounder with valid/ready on both sides.
//   i_clk, i_rst_n            : clock, synchronous active-low reset
//   i_valid / o_ready         : upstream handshake (o_ready is combinational)
//   i_man, i_exp, i_sign      : normalised extended mantissa, biased exponent, sign
//   i_rnd_mode                : 00 RNE, 01 RTZ, 10 RUP, 11 RDN
//   o_valid / i_ready         : downstream handshake
//   o_man_result, o_exp_result, o_sign : rounded result
//   o_inexact, o_overflow     : discarded bits nonzero / exponent overflowed
module rounding_pipe_unit
  import fp_round_pkg::*;
#(
  parameter int unsigned SIZE_MAN        = 28,
  parameter int unsigned SIZE_MAN_RESULT = 24,
  parameter int unsigned SIZE_EXP        = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [SIZE_MAN-1:0]        i_man,
  input  logic [SIZE_EXP-1:0]        i_exp,
  input  logic                       i_sign,
  input  logic [1:0]                 i_rnd_mode,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [SIZE_MAN_RESULT-1:0] o_man_result,
  output logic [SIZE_EXP-1:0]        o_exp_result,
  output logic                       o_sign,
  output logic                       o_inexact,
  output logic                       o_overflow
);

  localparam logic [SIZE_EXP-1:0] EXP_ALL_ONES   = '1;
  localparam logic [SIZE_EXP-1:0] EXP_MAX_FINITE = {{(SIZE_EXP-1){1'b1}}, 1'b0};

  logic v1, v2, en1, en2;

  assign en2     = ~v2 | i_ready;
  assign en1     = ~v1 | en2;
  assign o_ready = en1;
  assign o_valid = v2;

  // Stage 1: truncate and decide rounding
  logic                       dec_inc, dec_inexact;
  logic [SIZE_MAN_RESULT-1:0] s1_man;
  logic [SIZE_EXP-1:0]        s1_exp;
  s1_flags_t                  s1_flags;

  round_decide #(
    .SIZE_MAN        (SIZE_MAN),
    .SIZE_MAN_RESULT (SIZE_MAN_RESULT)
  ) u_round_decide (
    .man         (i_man),
    .exp_special (i_exp == EXP_ALL_ONES),
    .sign        (i_sign),
    .mode        (i_rnd_mode),
    .inc         (dec_inc),
    .inexact     (dec_inexact)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      v1       <= 1'b0;
      s1_man   <= '0;
      s1_exp   <= '0;
      s1_flags <= '0;
    end else if (en1) begin
      v1 <= i_valid;
      if (i_valid) begin
        s1_man           <= i_man[SIZE_MAN-1 -: SIZE_MAN_RESULT];
        s1_exp           <= i_exp;
        s1_flags.sign    <= i_sign;
        s1_flags.mode    <= rnd_mode_e'(i_rnd_mode);
        s1_flags.inc     <= dec_inc;
        s1_flags.inexact <= dec_inexact;
      end
    end
  end

  // Stage 2: increment, renormalise on carry, saturate on overflow
  logic [SIZE_MAN_RESULT:0]   sum;
  logic                       carry, ovf;
  logic [SIZE_EXP-1:0]        exp_adj, exp_n;
  logic [SIZE_MAN_RESULT-1:0] man_n;

  assign sum     = {1'b0, s1_man} + (SIZE_MAN_RESULT+1)'(s1_flags.inc);
  assign carry   = sum[SIZE_MAN_RESULT];
  assign exp_adj = s1_exp + SIZE_EXP'(carry);
  assign ovf     = carry && (exp_adj == EXP_ALL_ONES);

  always_comb begin
    man_n = carry ? sum[SIZE_MAN_RESULT:1] : sum[SIZE_MAN_RESULT-1:0];
    exp_n = exp_adj;
    if (ovf) begin
      if (to_infinity(s1_flags.mode, s1_flags.sign)) begin
        man_n = '0;
        exp_n = EXP_ALL_ONES;
      end else begin
        man_n = '1;
        exp_n = EXP_MAX_FINITE;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      v2           <= 1'b0;
      o_man_result <= '0;
      o_exp_result <= '0;
      o_sign       <= 1'b0;
      o_inexact    <= 1'b0;
      o_overflow   <= 1'b0;
    end else if (en2) begin
      v2 <= v1;
      if (v1) begin
        o_man_result <= man_n;
        o_exp_result <= exp_n;
        o_sign       <= s1_flags.sign;
        o_inexact    <= s1_flags.inexact;
        o_overflow   <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_rounding_pipe_unit.sv
// Scoreboard bench for rounding_pipe_unit: expected results are computed from
// the driven inputs by an arithmetic reference model and compared in order.
module tb_rounding_pipe_unit;

  logic        i_clk = 1'b0;
  logic        i_rst_n, i_valid, o_ready, i_sign, o_valid, i_ready;
  logic [27:0] i_man;
  logic [7:0]  i_exp;
  logic [1:0]  i_rnd_mode;
  logic [23:0] o_man_result;
  logic [7:0]  o_exp_result;
  logic        o_sign, o_inexact, o_overflow;

  always #5 i_clk = ~i_clk;

  rounding_pipe_unit #(
    .SIZE_MAN        (28),
    .SIZE_MAN_RESULT (24),
    .SIZE_EXP        (8)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_man        (i_man),
    .i_exp        (i_exp),
    .i_sign       (i_sign),
    .i_rnd_mode   (i_rnd_mode),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_man_result (o_man_result),
    .o_exp_result (o_exp_result),
    .o_sign       (o_sign),
    .o_inexact    (o_inexact),
    .o_overflow   (o_overflow)
  );

  typedef struct packed {
    logic [23:0] man;
    logic [7:0]  exp;
    logic        sign;
    logic        inexact;
    logic        ovf;
  } res_t;

  res_t        sb_q[$];
  res_t        held;
  logic [34:0] cur_out;
  int unsigned n_vec = 0, n_err = 0;
  bit          prev_stall = 0, saw_not_ready = 0, rand_done = 0;

  assign cur_out = {o_man_result, o_exp_result, o_sign, o_inexact, o_overflow};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference: round by comparing the 4 discarded bits against one half ulp.
  function automatic res_t ref_round(input logic [27:0] m, input logic [7:0] e,
                                     input logic s, input logic [1:0] md);
    res_t        r;
    logic [23:0] t;
    logic [3:0]  rem;
    logic [24:0] wide;
    logic        up;
    t = m[27:4];
    rem = m[3:0];
    r.sign = s;
    r.ovf = 1'b0;
    if (e == 8'hFF) begin
      r.man = t; r.exp = e; r.inexact = 1'b0;
      return r;
    end
    r.inexact = (rem != 4'd0);
    case (md)
      2'd0:    up = (rem > 4'd8) || (rem == 4'd8 && t[0]);
      2'd1:    up = 1'b0;
      2'd2:    up = !s && rem != 4'd0;
      default: up = s && rem != 4'd0;
    endcase
    wide = {1'b0, t} + {24'd0, up};
    if (wide[24]) begin
      r.man = wide[24:1];
      r.exp = e + 8'd1;
      if (r.exp == 8'hFF) begin
        r.ovf = 1'b1;
        if (md == 2'd0 || (md == 2'd2 && !s) || (md == 2'd3 && s)) r.man = 24'h0;
        else begin r.man = 24'hFFFFFF; r.exp = 8'hFE; end
      end
    end else begin
      r.man = wide[23:0];
      r.exp = e;
    end
    return r;
  endfunction

  // Monitor: inputs change only at posedge+1, so negedge sees what the next edge will.
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      sb_q.delete();
      prev_stall = 0;
    end else begin
      if (o_valid && i_ready) begin
        if (sb_q.size() == 0) check_eq("stray_output", o_valid, 0);
        else check_eq("result", cur_out, sb_q.pop_front());
      end
      if (o_valid && !i_ready) begin
        if (prev_stall) check_eq("hold_stable", cur_out, held);
        held = cur_out;
        prev_stall = 1;
      end else prev_stall = 0;
      if (!o_ready) saw_not_ready = 1;
      if (i_valid && o_ready) sb_q.push_back(ref_round(i_man, i_exp, i_sign, i_rnd_mode));
    end
  end

  task automatic send(input logic [27:0] m, input logic [7:0] e, input logic s, input logic [1:0] md);
    bit acc = 0;
    i_valid = 1'b1; i_man = m; i_exp = e; i_sign = s; i_rnd_mode = md;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge i_clk);
      acc = o_ready;
      @(posedge i_clk);
      #1;
    end
    if (!acc) check_eq("accept_timeout", o_ready, 1);
    i_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 50 && (sb_q.size() != 0 || o_valid); k++) @(posedge i_clk);
    #1;
    check_eq("drain_empty", sb_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [27:0] rm;
    i_rst_n = 0; i_valid = 0; i_man = '0; i_exp = '0; i_sign = 0; i_rnd_mode = '0; i_ready = 1;
    repeat (3) @(posedge i_clk);
    #1;
    check_eq("reset_valid", o_valid, 0);
    check_eq("reset_outputs", cur_out, 0);
    check_eq("reset_ready", o_ready, 1);
    i_rst_n = 1;

    // Latency: accepted at one edge, visible after the next
    send(28'h8000008, 8'h7F, 0, 2'd0);
    check_eq("latency_not_yet", o_valid, 0);
    @(posedge i_clk); #1;
    check_eq("latency_two", o_valid, 1);
    wait_drain();

    // Directed rounding cases
    send(28'h8000018, 8'h7F, 0, 2'd0);
    send(28'h8000018, 8'h7F, 0, 2'd1);
    send(28'hFFFFFF8, 8'h7F, 0, 2'd0);
    send(28'hFFFFFF8, 8'hFE, 0, 2'd0);
    send(28'hFFFFFFF, 8'hFE, 1, 2'd0);
    send(28'hFFFFFF8, 8'hFE, 1, 2'd2);
    send(28'h8000001, 8'h7F, 0, 2'd2);
    send(28'h8000001, 8'h7F, 0, 2'd3);
    send(28'h8000001, 8'h7F, 1, 2'd2);
    send(28'h8000001, 8'h7F, 1, 2'd3);
    for (int md = 0; md < 4; md++) send(28'h8000010, 8'h40, md[0], 2'(md));
    send(28'hFFFFFF8, 8'hFF, 0, 2'd0);
    send(28'h8000019, 8'hFF, 0, 2'd2);
    send(28'h0000000, 8'h05, 1, 2'd3);
    send(28'h8000009, 8'h10, 0, 2'd0);
    wait_drain();

    // Backpressure: stall downstream 3 cycles after first output
    saw_not_ready = 0;
    fork
      begin
        send(28'h8000018, 8'h20, 0, 2'd0);
        send(28'hFFFFFF8, 8'h21, 1, 2'd3);
        send(28'hABCDEF7, 8'h22, 0, 2'd2);
        send(28'h123456C, 8'h23, 1, 2'd0);
      end
      begin
        for (int k = 0; k < 20 && !o_valid; k++) begin @(posedge i_clk); #1; end
        i_ready = 0;
        repeat (3) @(posedge i_clk);
        #1;
        i_ready = 1;
      end
    join
    wait_drain();
    check_eq("backpressure_ready_drop", saw_not_ready, 1);

    // Random stream with random downstream readiness
    rand_done = 0;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          rm = {1'b1, 27'($urandom)};
          if (n % 4 == 0) rm[3:0] = 4'h8;
          send(rm, 8'($urandom_range(0, 255)), 1'($urandom), 2'($urandom));
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge i_clk); #1;
          i_ready = ($urandom_range(0, 3) != 0);
        end
        i_ready = 1;
      end
    join
    wait_drain();

    // Reset with two items in flight
    send(28'h8000008, 8'h30, 0, 2'd0);
    send(28'h8000018, 8'h31, 0, 2'd0);
    i_rst_n = 0;
    @(posedge i_clk); #1;
    check_eq("midreset_valid", o_valid, 0);
    check_eq("midreset_outputs", cur_out, 0);
    i_rst_n = 1;
    repeat (6) @(posedge i_clk);
    #1;
    check_eq("post_reset_idle", o_valid, 0);
    check_eq("post_reset_queue", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rounding_pipe_unit.md
Name: rounding_pipe_unit

Overview:
Parametrised, pipelined successor to the truncating mantissa rounder in the FP add/sub datapath. It takes a normalised extended mantissa with guard, round and sticky bits, plus its exponent and sign, and applies one of four IEEE-754 rounding modes. It handles mantissa carry-out by renormalising and incrementing the exponent, and flags inexact and overflow results. It sits between the normalisation shifter and result packing, with a valid/ready handshake on both sides and 2-cycle latency.

Parameters:
SIZE_MAN, 28, width of incoming extended mantissa (hidden bit + fraction + G/R/S field); must be >= SIZE_MAN_RESULT+3
SIZE_MAN_RESULT, 24, width of rounded mantissa (hidden bit + fraction)
SIZE_EXP, 8, exponent width

Ports:
i_clk  input  1  clock
i_rst_n  input  1  synchronous active-low reset
i_valid  input  1  upstream data valid
o_ready  output  1  block can accept input this cycle
i_man  input  SIZE_MAN  normalised mantissa, MSB = hidden bit
i_exp  input  SIZE_EXP  biased exponent
i_sign  input  1  sign of result
i_rnd_mode  input  2  rounding mode: 00 RNE, 01 RTZ, 10 RUP (toward +inf), 11 RDN (toward -inf)
o_valid  output  1  output data valid
i_ready  input  1  downstream accepts output
o_man_result  output  SIZE_MAN_RESULT  rounded mantissa
o_exp_result  output  SIZE_EXP  adjusted exponent
o_sign  output  1  sign, passed through
o_inexact  output  1  any discarded bit was 1
o_overflow  output  1  rounding carried the exponent to all-ones

Behaviour:
- Clock is i_clk; reset is synchronous, active-low on i_rst_n.
- Reset (i_rst_n=0 at a rising edge): both stage valids cleared; all output data registers cleared to 0. Reset mid-operation discards in-flight data with no output.
- Field split:
  - truncated mantissa T = i_man[SIZE_MAN-1 -: SIZE_MAN_RESULT]
  - L = LSB of T
  - G = i_man[SIZE_MAN-SIZE_MAN_RESULT-1]
  - R = next bit down
  - S = OR of all remaining lower bits
- Stage 1 (registered): T, exp, sign, mode, inexact = G|R|S, and inc, where:
  - RNE: inc = G & (R|S|L)
  - RTZ: inc = 0
  - RUP: inc = ~sign & (G|R|S)
  - RDN: inc = sign & (G|R|S)
- Special input: i_exp all-ones (Inf/NaN) forces inc=0 and inexact=0; mantissa passes through unchanged.
- Stage 2 (registered): sum = {1'b0,T} + inc.
  - If sum carries out: mantissa = sum[SIZE_MAN_RESULT:1] (= 1000...0) and exp = exp+1.
  - Otherwise: mantissa = sum[SIZE_MAN_RESULT-1:0], exp unchanged.
- Overflow occurs when the carry makes exp all-ones; o_overflow=1 and:
  - RNE; RUP with sign=0; RDN with sign=1: output infinity (exp all-ones, mantissa 0).
  - RTZ; RUP with sign=1; RDN with sign=0: output max finite (exp all-ones-1, mantissa all-ones).
  - These RTZ/directed cases cannot carry in practice; the rule is stated for completeness.
- Zero mantissa input passes through as zero with the same exp and inexact=0.
- Handshake:
  - en2 = ~v2 | i_ready; en1 = ~v1 | en2; o_ready = en1 (combinational, no path from i_valid).
  - Stage 1 loads when en1: v1 <= i_valid.
  - Stage 2 loads when en2: v2 <= v1.
  - o_valid = v2.
  - While o_valid & ~i_ready, all outputs are held stable.
- Throughput 1/cycle with i_ready=1. Latency 2 cycles from input handshake to o_valid.
- Simultaneous input accept and output drain while full is legal; there is no bubble.

Decomposition:
- Shared package fp_round_pkg:
  - rnd_mode_e enum (RNE, RTZ, RUP, RDN)
  - localparam helpers for exponent all-ones
  - struct for the stage-1 payload (man, exp, sign, mode, inc, inexact)
- One natural sub-module: round_decide (combinational G/R/S extraction + inc/inexact), instantiated ahead of the stage-1 register.

Test Plan:
1. RNE tie, even: i_man=28'h8000008, exp 8'h7F -> 2 cycles later o_man_result=24'h800000, exp 8'h7F, o_inexact=1, o_overflow=0.
2. RNE tie, odd: i_man=28'h8000018 -> o_man_result=24'h800002, o_inexact=1. Same input with RTZ -> 24'h800001.
3. Carry renormalise: i_man=28'hFFFFFF8, exp 8'h7F, RNE -> o_man_result=24'h800000, exp 8'h80. Same input with exp 8'hFE -> exp 8'hFF, man 0, o_overflow=1.
4. Directed modes: i_man=28'h8000001, sign=0 -> RUP gives 24'h800001, RDN gives 24'h800000. With sign=1 the results swap. Exact input 28'h8000010 in any mode -> o_inexact=0.
5. Backpressure: stream 4 items with i_ready low for 3 cycles after the first o_valid -> o_ready drops once both stages are full, outputs stay stable, all 4 results emerge in order with none lost or duplicated.
6. Reset mid-stream: assert i_rst_n=0 for 1 cycle with 2 items in flight -> o_valid=0 and outputs 0 next cycle; no stale items emerge afterwards.
